// File: rtl/execute_multicycle_ctrl_pkg.sv
// rtl/execute_multicycle_ctrl_pkg.sv - shared constants, state enum and control register for the multicycle sequencer
package execute_multicycle_ctrl_pkg;

  localparam int MCU_NUM_UNITS = 4;
  localparam int MCU_XLEN      = 32;
  localparam int MCU_FLAG_W    = 5;
  localparam int MCU_UNIT_W    = $clog2(MCU_NUM_UNITS);
  // One extra code point so an out-of-range unit index can be presented and rejected
  localparam int MCU_ISSUE_W   = $clog2(MCU_NUM_UNITS + 1);

  typedef enum logic [1:0] {
    MCU_IDLE,
    MCU_RUN,
    MCU_DONE,
    MCU_FLUSH
  } mcu_state_type;

  typedef struct packed {
    mcu_state_type         state;
    logic [MCU_UNIT_W-1:0] unit;
    logic [4:0]            waddr;
    logic [MCU_XLEN-1:0]   result;
    logic [MCU_FLAG_W-1:0] flags;
    logic                  err;
  } mcu_ctrl_reg_type;

  localparam mcu_ctrl_reg_type init_mcu_ctrl_reg = '{
    state:  MCU_IDLE,
    unit:   '0,
    waddr:  '0,
    result: '0,
    flags:  '0,
    err:    1'b0
  };

endpackage

// File: rtl/execute_multicycle_ctrl_if.sv
// rtl/execute_multicycle_ctrl_if.sv - issue, unit-array and writeback signals of the multicycle sequencer
interface execute_multicycle_ctrl_if;
  import execute_multicycle_ctrl_pkg::*;

  logic                                issue_valid;
  logic [MCU_ISSUE_W-1:0]              issue_unit;
  logic [4:0]                          issue_waddr;
  logic                                clear;
  logic [MCU_NUM_UNITS-1:0]            unit_enable;
  logic [MCU_NUM_UNITS-1:0]            unit_ready;
  logic [MCU_NUM_UNITS*MCU_XLEN-1:0]   unit_result;
  logic [MCU_NUM_UNITS*MCU_FLAG_W-1:0] unit_flags;
  logic                                stall;
  logic                                wb_valid;
  logic [4:0]                          wb_waddr;
  logic [MCU_XLEN-1:0]                 wb_data;
  logic [MCU_FLAG_W-1:0]               wb_flags;
  logic                                timeout_err;
  logic                                busy;

  modport master (
    output issue_valid, issue_unit, issue_waddr, clear,
    output unit_ready, unit_result, unit_flags,
    input  unit_enable, stall, wb_valid, wb_waddr, wb_data, wb_flags, timeout_err, busy
  );

  modport slave (
    input  issue_valid, issue_unit, issue_waddr, clear,
    input  unit_ready, unit_result, unit_flags,
    output unit_enable, stall, wb_valid, wb_waddr, wb_data, wb_flags, timeout_err, busy
  );

endinterface

// File: rtl/execute_multicycle_ctrl_timeout_counter.sv
// rtl/execute_multicycle_ctrl_timeout_counter.sv - saturating wait counter flagging an expired unit
module mcu_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int              CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/execute_multicycle_ctrl.sv
// rtl/execute_multicycle_ctrl.sv - single-outstanding-op sequencer for the execute stage's long-latency units
module execute_multicycle_ctrl
  import execute_multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input logic                      clk,
  input logic                      rst,
  execute_multicycle_ctrl_if.slave bus
);

  mcu_ctrl_reg_type      r_q, r_d;
  logic                  cnt_clr, cnt_en, expired;
  logic                  issue_ok, issue_legal;
  logic                  sel_ready;
  logic [MCU_XLEN-1:0]   sel_result;
  logic [MCU_FLAG_W-1:0] sel_flags;

  mcu_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .enable_i  (cnt_en),
    .clear_i   (cnt_clr),
    .expired_o (expired)
  );

  // Only the unit latched at issue may complete the op; other ready bits are ignored
  always_comb begin
    sel_ready  = 1'b0;
    sel_result = '0;
    sel_flags  = '0;
    for (int i = 0; i < MCU_NUM_UNITS; i++) begin
      if (r_q.unit == MCU_UNIT_W'(i)) begin
        sel_ready  = bus.unit_ready[i];
        sel_result = bus.unit_result[i*MCU_XLEN +: MCU_XLEN];
        sel_flags  = bus.unit_flags[i*MCU_FLAG_W +: MCU_FLAG_W];
      end
    end
  end

  always_comb begin
    r_d             = r_q;
    bus.unit_enable = '0;
    bus.stall       = 1'b0;
    cnt_clr         = 1'b0;
    cnt_en          = 1'b0;
    issue_ok        = bus.issue_valid & ~bus.clear;
    issue_legal     = bus.issue_unit < MCU_ISSUE_W'(MCU_NUM_UNITS);

    case (r_q.state)
      MCU_IDLE, MCU_DONE: begin
        r_d.state = MCU_IDLE;
        r_d.err   = 1'b0;
        if (issue_ok) begin
          bus.stall = 1'b1;
          cnt_clr   = 1'b1;
          r_d.unit  = bus.issue_unit[MCU_UNIT_W-1:0];
          r_d.waddr = bus.issue_waddr;
          if (issue_legal) begin
            bus.unit_enable[bus.issue_unit[MCU_UNIT_W-1:0]] = 1'b1;
            r_d.state = MCU_RUN;
          end else begin
            r_d.state  = MCU_DONE;
            r_d.result = '0;
            r_d.flags  = '0;
            r_d.err    = 1'b1;
          end
        end
      end
      MCU_RUN: begin
        bus.stall = 1'b1;
        cnt_en    = 1'b1;
        if (bus.clear) begin
          r_d.state = sel_ready ? MCU_IDLE : MCU_FLUSH;
        end else if (sel_ready) begin
          r_d.state  = MCU_DONE;
          r_d.result = sel_result;
          r_d.flags  = sel_flags;
          r_d.err    = 1'b0;
        end else if (expired) begin
          r_d.state  = MCU_DONE;
          r_d.result = '0;
          r_d.flags  = '0;
          r_d.err    = 1'b1;
        end
      end
      MCU_FLUSH: begin
        // Killed op still occupies its unit; hold the stage until it drains or times out
        bus.stall = 1'b1;
        cnt_en    = 1'b1;
        if (sel_ready || expired) begin
          r_d.state = MCU_IDLE;
        end
      end
      default: r_d = init_mcu_ctrl_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= init_mcu_ctrl_reg;
    end else begin
      r_q <= r_d;
    end
  end

  assign bus.wb_valid    = (r_q.state == MCU_DONE) & ~bus.clear;
  assign bus.timeout_err = (r_q.state == MCU_DONE) & r_q.err & ~bus.clear;
  assign bus.wb_waddr    = r_q.waddr;
  assign bus.wb_data     = r_q.result;
  assign bus.wb_flags    = r_q.flags;
  assign bus.busy        = (r_q.state != MCU_IDLE);

endmodule

// File: tb/tb_execute_multicycle_ctrl.sv
// tb/tb_execute_multicycle_ctrl.sv - directed self-checking bench for execute_multicycle_ctrl
module tb_execute_multicycle_ctrl;
  import execute_multicycle_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   stall_cnt;
  int   en_cnt;
  int   wb_cnt;

  execute_multicycle_ctrl_if bus ();

  execute_multicycle_ctrl #(.TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.issue_valid = 1'b0;
    bus.issue_unit  = '0;
    bus.issue_waddr = '0;
    bus.clear       = 1'b0;
    bus.unit_ready  = '0;
  endtask

  task automatic issue(input int unit, input int waddr);
    bus.issue_valid = 1'b1;
    bus.issue_unit  = MCU_ISSUE_W'(unit);
    bus.issue_waddr = 5'(waddr);
  endtask

  task automatic set_unit(input int unit, input logic [31:0] res, input logic [4:0] flg);
    bus.unit_result[unit*MCU_XLEN +: MCU_XLEN]     = res;
    bus.unit_flags[unit*MCU_FLAG_W +: MCU_FLAG_W] = flg;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    quiet();
    bus.unit_result = '0;
    bus.unit_flags  = '0;
    tick();
    tick();
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_wb_data", 64'(bus.wb_data), 64'd0);
    check("rst_enable", 64'(bus.unit_enable), 64'd0);
    check("rst_err", 64'(bus.timeout_err), 64'd0);
    rst = 1'b0;
    tick();

    // Basic op: unit 2 ready four cycles after issue
    issue(2, 7);
    #1;
    check("t1_enable", 64'(bus.unit_enable), 64'h4);
    stall_cnt = int'(bus.stall);
    en_cnt    = int'(|bus.unit_enable);
    tick();
    quiet();
    for (int t = 1; t <= 4; t++) begin
      if (t == 4) begin
        bus.unit_ready = 4'b0100;
        set_unit(2, 32'hDEADBEEF, 5'h03);
      end
      #1;
      stall_cnt += int'(bus.stall);
      en_cnt    += int'(|bus.unit_enable);
      check("t1_no_wb", 64'(bus.wb_valid), 64'd0);
      tick();
    end
    quiet();
    #1;
    check("t1_stall_cycles", 64'(stall_cnt), 64'd5);
    check("t1_enable_pulses", 64'(en_cnt), 64'd1);
    check("t1_wb_valid", 64'(bus.wb_valid), 64'd1);
    check("t1_wb_waddr", 64'(bus.wb_waddr), 64'd7);
    check("t1_wb_data", 64'(bus.wb_data), 64'hDEADBEEF);
    check("t1_wb_flags", 64'(bus.wb_flags), 64'h3);
    check("t1_err", 64'(bus.timeout_err), 64'd0);
    check("t1_done_stall", 64'(bus.stall), 64'd0);
    tick();
    #1;
    check("t1_wb_drop", 64'(bus.wb_valid), 64'd0);
    check("t1_idle", 64'(bus.busy), 64'd0);

    // Back-to-back: unit 1 issued during unit 0's writeback cycle
    issue(0, 3);
    tick();
    quiet();
    bus.unit_ready = 4'b0001;
    set_unit(0, 32'hAAAA0001, 5'h01);
    tick();
    quiet();
    issue(1, 4);
    #1;
    check("t2_wb0_valid", 64'(bus.wb_valid), 64'd1);
    check("t2_wb0_data", 64'(bus.wb_data), 64'hAAAA0001);
    check("t2_wb0_waddr", 64'(bus.wb_waddr), 64'd3);
    check("t2_enable1", 64'(bus.unit_enable), 64'h2);
    tick();
    quiet();
    bus.unit_ready = 4'b0010;
    set_unit(1, 32'hBBBB0002, 5'h02);
    #1;
    check("t2_no_reenable", 64'(bus.unit_enable), 64'd0);
    tick();
    quiet();
    #1;
    check("t2_wb1_valid", 64'(bus.wb_valid), 64'd1);
    check("t2_wb1_data", 64'(bus.wb_data), 64'hBBBB0002);
    check("t2_wb1_waddr", 64'(bus.wb_waddr), 64'd4);
    tick();

    // Clear two cycles after issue; unit drains at cycle 6
    issue(1, 9);
    tick();
    quiet();
    stall_cnt = 0;
    wb_cnt    = 0;
    for (int t = 1; t <= 6; t++) begin
      bus.clear      = (t == 2);
      bus.unit_ready = (t == 6) ? 4'b0010 : 4'b0000;
      #1;
      stall_cnt += int'(bus.stall);
      wb_cnt    += int'(bus.wb_valid);
      tick();
    end
    quiet();
    #1;
    check("t3_stall_cycles", 64'(stall_cnt), 64'd6);
    check("t3_no_wb", 64'(wb_cnt), 64'd0);
    check("t3_idle", 64'(bus.busy), 64'd0);
    check("t3_idle_wb", 64'(bus.wb_valid), 64'd0);
    tick();

    // Timeout with TIMEOUT=8: eight RUN cycles, then error writeback
    issue(3, 12);
    tick();
    quiet();
    stall_cnt = 0;
    wb_cnt    = 0;
    for (int t = 1; t <= 8; t++) begin
      #1;
      stall_cnt += int'(bus.stall);
      wb_cnt    += int'(bus.wb_valid);
      tick();
    end
    #1;
    check("t4_stall_cycles", 64'(stall_cnt), 64'd8);
    check("t4_early_wb", 64'(wb_cnt), 64'd0);
    check("t4_wb_valid", 64'(bus.wb_valid), 64'd1);
    check("t4_err", 64'(bus.timeout_err), 64'd1);
    check("t4_wb_data", 64'(bus.wb_data), 64'd0);
    check("t4_wb_flags", 64'(bus.wb_flags), 64'd0);
    check("t4_wb_waddr", 64'(bus.wb_waddr), 64'd12);
    tick();
    #1;
    check("t4_busy_drop", 64'(bus.busy), 64'd0);
    check("t4_err_drop", 64'(bus.timeout_err), 64'd0);

    // Spurious ready from unit 3 while unit 1 owns the op
    issue(1, 5);
    tick();
    quiet();
    wb_cnt = 0;
    for (int t = 1; t <= 3; t++) begin
      bus.unit_ready = (t == 3) ? 4'b0010 : 4'b1000;
      set_unit(3, 32'h00000033, 5'h1f);
      set_unit(1, 32'h11111111, 5'h04);
      #1;
      wb_cnt += int'(bus.wb_valid);
      tick();
    end
    quiet();
    #1;
    check("t5_ignored", 64'(wb_cnt), 64'd0);
    check("t5_wb_valid", 64'(bus.wb_valid), 64'd1);
    check("t5_wb_data", 64'(bus.wb_data), 64'h11111111);
    check("t5_wb_flags", 64'(bus.wb_flags), 64'h4);
    tick();

    // Asynchronous reset while RUN
    issue(0, 6);
    tick();
    quiet();
    #3;
    rst = 1'b1;
    #1;
    check("t6_busy", 64'(bus.busy), 64'd0);
    check("t6_stall", 64'(bus.stall), 64'd0);
    check("t6_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("t6_wb_data", 64'(bus.wb_data), 64'd0);
    check("t6_enable", 64'(bus.unit_enable), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Out-of-range unit index
    issue(4, 2);
    #1;
    check("t7_no_enable", 64'(bus.unit_enable), 64'd0);
    tick();
    quiet();
    #1;
    check("t7_wb_valid", 64'(bus.wb_valid), 64'd1);
    check("t7_err", 64'(bus.timeout_err), 64'd1);
    check("t7_wb_data", 64'(bus.wb_data), 64'd0);
    check("t7_wb_waddr", 64'(bus.wb_waddr), 64'd2);
    tick();
    #1;
    check("t7_idle", 64'(bus.busy), 64'd0);

    // Clear during writeback suppresses it
    issue(0, 8);
    tick();
    quiet();
    bus.unit_ready = 4'b0001;
    tick();
    quiet();
    bus.clear = 1'b1;
    #1;
    check("t8_wb_killed", 64'(bus.wb_valid), 64'd0);
    tick();
    quiet();

    // Ready and clear together in RUN go straight to IDLE
    issue(2, 10);
    tick();
    quiet();
    bus.unit_ready = 4'b0100;
    bus.clear      = 1'b1;
    tick();
    quiet();
    #1;
    check("t9_idle", 64'(bus.busy), 64'd0);
    check("t9_no_wb", 64'(bus.wb_valid), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
